// File: rtl/aibcr3_dcc_dlyctl_gen2.sv
`default_nettype none
//============================================================================
// Module  : aibcr3_dcc_dlyctl_gen2
// Brief   : Multi-channel delay-code slew controller with gray-coded outputs.
//           Optional scan chain over the live codes: AIBCR3_DCC_DLYCTL_SCAN_EN
// Revision: 1.0 - initial release
//============================================================================
module aibcr3_dcc_dlyctl_gen2 #(
  parameter int NCH      = 2,
  parameter int CODE_W   = 11,
  parameter int STEP_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dll_lock,
  input  logic [NCH-1:0]        tgt_vld,
  input  logic [NCH*CODE_W-1:0] tgt_code,
  output logic [NCH-1:0]        tgt_rdy,
  output logic [NCH-1:0]        settled,
  output logic [NCH*CODE_W-1:0] gray,
  output logic [NCH-1:0]        sel_clk,
  input  logic                  scan_en,
  input  logic                  scan_in,
  output logic                  scan_out
);

  localparam int              DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam int              CHAIN_W  = NCH * CODE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLEW = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  logic               scan_act;
  logic [CHAIN_W-1:0] cur_all;
  logic [CHAIN_W-1:0] cur_step_all;
  logic [CHAIN_W-1:0] cur_all_d;

`ifdef AIBCR3_DCC_DLYCTL_SCAN_EN
  // Chain is {cur[NCH-1],...,cur[0]}, shifted towards bit 0.
  assign scan_act  = scan_en;
  assign scan_out  = cur_all[0];
  assign cur_all_d = scan_en ? {scan_in, cur_all[CHAIN_W-1:1]} : cur_step_all;
`else
  logic unused_scan;
  assign unused_scan = scan_en ^ scan_in ^ (^cur_all);
  assign scan_act    = 1'b0;
  assign scan_out    = 1'b0;
  assign cur_all_d   = cur_step_all;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t              state_q, state_d;
    logic [CODE_W-1:0]   cur_q, cur_d, cur_step;
    logic [CODE_W-1:0]   tgt_q, tgt_d;
    logic [CODE_W-1:0]   gray_q, gray_d;
    logic [CODE_W-1:0]   code_in;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                sel_q, sel_d;

    assign code_in                       = tgt_code[c*CODE_W +: CODE_W];
    assign cur_all[c*CODE_W +: CODE_W]      = cur_q;
    assign cur_step_all[c*CODE_W +: CODE_W] = cur_step;
    assign cur_d                         = cur_all_d[c*CODE_W +: CODE_W];

    always_comb begin
      state_d  = state_q;
      tgt_d    = tgt_q;
      div_d    = div_q;
      cur_step = cur_q;
      gray_d   = cur_q ^ (cur_q >> 1);
      sel_d    = (state_q == ST_IDLE) ? dll_lock : sel_q;
      case (state_q)
        ST_IDLE: begin
          if (tgt_vld[c]) begin
            tgt_d   = code_in;
            div_d   = '0;
            state_d = (code_in != cur_q) ? ST_SLEW : ST_HOLD;
          end
        end
        ST_SLEW: begin
          // A scan load can land exactly on the target; stepping would then run away.
          if (cur_q == tgt_q) begin
            state_d = ST_HOLD;
            div_d   = '0;
          end else if (div_q == DIV_LAST) begin
            div_d    = '0;
            cur_step = (tgt_q > cur_q) ? cur_q + 1'b1 : cur_q - 1'b1;
            if (cur_step == tgt_q) begin
              state_d = ST_HOLD;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            state_d = ST_IDLE;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          div_d   = '0;
        end
      endcase
      if (scan_act) begin
        state_d = state_q;
        tgt_d   = tgt_q;
        div_d   = div_q;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_IDLE;
        cur_q   <= '0;
        tgt_q   <= '0;
        div_q   <= '0;
        gray_q  <= '0;
        sel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cur_q   <= cur_d;
        tgt_q   <= tgt_d;
        div_q   <= div_d;
        gray_q  <= gray_d;
        sel_q   <= sel_d;
      end
    end

    assign tgt_rdy[c]                = (state_q == ST_IDLE);
    assign settled[c]                = (state_q == ST_IDLE) && (cur_q == tgt_q);
    assign gray[c*CODE_W +: CODE_W]  = gray_q;
    assign sel_clk[c]                = sel_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_aibcr3_dcc_dlyctl_gen2.sv
`default_nettype none
//============================================================================
// Module  : tb_aibcr3_dcc_dlyctl_gen2
// Brief   : Scoreboard bench for the delay-code slew controller.
// Revision: 1.0 - initial release
//============================================================================
module tb_aibcr3_dcc_dlyctl_gen2;

  localparam int NCH      = 2;
  localparam int CODE_W   = 11;
  localparam int STEP_DIV = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  dll_lock;
  logic [NCH-1:0]        tgt_vld;
  logic [NCH*CODE_W-1:0] tgt_code;
  logic [NCH-1:0]        tgt_rdy;
  logic [NCH-1:0]        settled;
  logic [NCH*CODE_W-1:0] gray;
  logic [NCH-1:0]        sel_clk;
  logic                  scan_en;
  logic                  scan_in;
  logic                  scan_out;

  aibcr3_dcc_dlyctl_gen2 #(
    .NCH      (NCH),
    .CODE_W   (CODE_W),
    .STEP_DIV (STEP_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .dll_lock (dll_lock),
    .tgt_vld  (tgt_vld),
    .tgt_code (tgt_code),
    .tgt_rdy  (tgt_rdy),
    .settled  (settled),
    .gray     (gray),
    .sel_clk  (sel_clk),
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .scan_out (scan_out)
  );

  typedef struct packed {
    logic [31:0]       t;
    logic [CODE_W-1:0] g;
  } sb_t;

  sb_t  q0[$];
  sb_t  q1[$];
  logic sbit_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int model[NCH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CODE_W-1:0] g2(input logic [CODE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic void sb_push(input int c, input sb_t e);
    if (c == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic int sb_size(input int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  function automatic sb_t sb_pop(input int c);
    if (c == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic test_reset;
    reset    = 1'b1;
    dll_lock = 1'b0;
    tgt_vld  = '0;
    tgt_code = '0;
    scan_en  = 1'b0;
    scan_in  = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (gray !== '0)       begin n_err++; $display("FAIL reset_gray: got %h expected 0", gray); end
    n_cmp++; if (tgt_rdy !== 2'b11) begin n_err++; $display("FAIL reset_rdy: got %b expected 11", tgt_rdy); end
    n_cmp++; if (settled !== 2'b11) begin n_err++; $display("FAIL reset_settled: got %b expected 11", settled); end
    n_cmp++; if (sel_clk !== 2'b00) begin n_err++; $display("FAIL reset_sel: got %b expected 00", sel_clk); end
    n_cmp++; if (scan_out !== 1'b0) begin n_err++; $display("FAIL reset_scan_out: got %b expected 0", scan_out); end
    reset    = 1'b0;
    model[0] = 0;
    model[1] = 0;
  endtask

  // Accepts targets on the masked channels, optionally pulses an ignored target mid-slew,
  // and scores every gray transition against the expected value and cycle.
  task automatic test_slew(input logic [NCH-1:0] mask, input int t0, input int t1, input int ign_at);
    int                T, budget, d, v;
    int                tgt[NCH];
    int                rdy_exp[NCH];
    int                rdy_seen[NCH];
    logic [CODE_W-1:0] prev[NCH];
    logic [CODE_W-1:0] now;
    sb_t               e;
    tgt[0] = t0;
    tgt[1] = t1;
    @(negedge clk);
    tgt_code = {CODE_W'(t1), CODE_W'(t0)};
    tgt_vld  = mask;
    @(negedge clk);
    tgt_vld = '0;
    T       = cyc;
    budget  = 2;
    for (int c = 0; c < NCH; c++) begin
      prev[c]     = gray[c*CODE_W +: CODE_W];
      rdy_seen[c] = -1;
      rdy_exp[c]  = T + 1;
      if (mask[c]) begin
        d = (tgt[c] > model[c]) ? tgt[c] - model[c] : model[c] - tgt[c];
        for (int k = 1; k <= d; k++) begin
          v   = (tgt[c] > model[c]) ? model[c] + k : model[c] - k;
          e.t = 32'(T + k*STEP_DIV + 1);
          e.g = g2(CODE_W'(v));
          sb_push(c, e);
        end
        rdy_exp[c] = T + (d + 1)*STEP_DIV;
        if ((d + 1)*STEP_DIV + 2 > budget) budget = (d + 1)*STEP_DIV + 2;
        model[c] = tgt[c];
        n_cmp++;
        if (tgt_rdy[c] !== 1'b0) begin
          n_err++; $display("FAIL accept_rdy ch%0d: got %b expected 0", c, tgt_rdy[c]);
        end
      end
    end
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        now = gray[c*CODE_W +: CODE_W];
        if (now !== prev[c]) begin
          n_cmp++;
          if (sb_size(c) == 0) begin
            n_err++; $display("FAIL gray_extra ch%0d: got %h at cycle %0d expected no change", c, now, cyc - T);
          end else begin
            e = sb_pop(c);
            if (now !== e.g || cyc != int'(e.t)) begin
              n_err++;
              $display("FAIL gray_step ch%0d: got %h at cycle %0d expected %h at cycle %0d", c, now, cyc - T, e.g, int'(e.t) - T);
            end
            n_cmp++;
            if ($countones(now ^ prev[c]) != 1) begin
              n_err++; $display("FAIL gray_onebit ch%0d: got %h after %h expected one bit change", c, now, prev[c]);
            end
          end
        end
        prev[c] = now;
        if (tgt_rdy[c] && rdy_seen[c] < 0) rdy_seen[c] = cyc;
      end
      tgt_vld = (i == ign_at) ? mask : '0;
      if (i == ign_at) tgt_code = {NCH{CODE_W'(100)}};
    end
    for (int c = 0; c < NCH; c++) begin
      n_cmp++;
      if (sb_size(c) != 0) begin
        n_err++; $display("FAIL gray_missing ch%0d: got %0d steps outstanding expected 0", c, sb_size(c));
      end
      n_cmp++;
      if (rdy_seen[c] != rdy_exp[c]) begin
        n_err++; $display("FAIL rdy_time ch%0d: got cycle %0d expected cycle %0d", c, rdy_seen[c] - T, rdy_exp[c] - T);
      end
      n_cmp++;
      if (settled[c] !== 1'b1) begin
        n_err++; $display("FAIL settled ch%0d: got %b expected 1", c, settled[c]);
      end
      n_cmp++;
      if (gray[c*CODE_W +: CODE_W] !== g2(CODE_W'(model[c]))) begin
        n_err++; $display("FAIL final_gray ch%0d: got %h expected %h", c, gray[c*CODE_W +: CODE_W], g2(CODE_W'(model[c])));
      end
    end
    while (sb_size(0) != 0) void'(sb_pop(0));
    while (sb_size(1) != 0) void'(sb_pop(1));
  endtask

  task automatic test_sel_clk;
    int   T;
    logic exp0;
    @(negedge clk);
    tgt_code = {CODE_W'(model[1]), CODE_W'(11)};
    tgt_vld  = 2'b01;
    @(negedge clk);
    tgt_vld  = '0;
    T        = cyc;
    dll_lock = 1'b1;
    n_cmp++;
    if (sel_clk !== 2'b00) begin n_err++; $display("FAIL sel_at_accept: got %b expected 00", sel_clk); end
    // d = 5: ch0 is IDLE from T+24 and samples dll_lock on the following edge.
    for (int i = 1; i <= 6*STEP_DIV + 4; i++) begin
      @(negedge clk);
      exp0 = (cyc >= T + 6*STEP_DIV + 1);
      n_cmp++;
      if (sel_clk !== {1'b1, exp0}) begin
        n_err++; $display("FAIL sel_clk: got %b at cycle %0d expected %b", sel_clk, cyc - T, {1'b1, exp0});
      end
    end
    model[0] = 11;
  endtask

  task automatic test_scan;
    int                      T, start, rdy_seen;
    logic [NCH*CODE_W-1:0]   oldv, newv;
    logic                    b;
    start = model[0];
    @(negedge clk);
`ifdef AIBCR3_DCC_DLYCTL_SCAN_EN
    tgt_code = {CODE_W'(model[1]), CODE_W'(20)};
    tgt_vld  = 2'b01;
    @(negedge clk);
    tgt_vld = '0;
    T       = cyc;
    repeat (6) @(negedge clk);
    oldv = {CODE_W'(model[1]), CODE_W'(start + 1)};
    newv = {CODE_W'(11'h001), CODE_W'(11'h3FF)};
    for (int j = 0; j < NCH*CODE_W; j++) sbit_q.push_back(oldv[j]);
    scan_en = 1'b1;
    for (int j = 0; j < NCH*CODE_W; j++) begin
      if (j > 0) @(negedge clk);
      b = sbit_q.pop_front();
      n_cmp++;
      if (scan_out !== b) begin n_err++; $display("FAIL scan_out bit%0d: got %b expected %b", j, scan_out, b); end
      n_cmp++;
      if (tgt_rdy[0] !== 1'b0) begin n_err++; $display("FAIL scan_frozen bit%0d: got rdy %b expected 0", j, tgt_rdy[0]); end
      scan_in = newv[j];
    end
    @(negedge clk);
    scan_en = 1'b0;
    scan_in = 1'b0;
    @(negedge clk);
    n_cmp++; if (gray[CODE_W-1:0] !== g2(11'h3FF)) begin n_err++; $display("FAIL scan_load0: got %h expected %h", gray[CODE_W-1:0], g2(11'h3FF)); end
    n_cmp++; if (gray[2*CODE_W-1:CODE_W] !== g2(11'h001)) begin n_err++; $display("FAIL scan_load1: got %h expected %h", gray[2*CODE_W-1:CODE_W], g2(11'h001)); end
    n_cmp++; if (settled[1] !== 1'b0) begin n_err++; $display("FAIL scan_settled1: got %b expected 0", settled[1]); end
    n_cmp++; if (tgt_rdy[1] !== 1'b1) begin n_err++; $display("FAIL scan_idle1: got %b expected 1", tgt_rdy[1]); end
    @(negedge clk);
    n_cmp++; if (gray[CODE_W-1:0] !== g2(11'h3FF)) begin n_err++; $display("FAIL scan_hold_div: got %h expected %h", gray[CODE_W-1:0], g2(11'h3FF)); end
    @(negedge clk);
    n_cmp++; if (gray[CODE_W-1:0] !== g2(11'h3FE)) begin n_err++; $display("FAIL scan_resume: got %h expected %h", gray[CODE_W-1:0], g2(11'h3FE)); end
    rdy_seen = -1;
    for (int i = 0; i < 4100 && rdy_seen < 0; i++) begin
      @(negedge clk);
      if (tgt_rdy[0]) rdy_seen = cyc;
    end
    // 1003 steps from 0x3FF to 20, first at T+30, then one hold period.
    n_cmp++; if (rdy_seen != T + 4042) begin n_err++; $display("FAIL scan_done_time: got cycle %0d expected cycle 4042", rdy_seen - T); end
    n_cmp++; if (gray[CODE_W-1:0] !== g2(11'd20)) begin n_err++; $display("FAIL scan_final: got %h expected %h", gray[CODE_W-1:0], g2(11'd20)); end
    n_cmp++; if (settled[0] !== 1'b1) begin n_err++; $display("FAIL scan_settled0: got %b expected 1", settled[0]); end
    model[0] = 20;
    model[1] = 1;
`else
    tgt_code = {CODE_W'(model[1]), CODE_W'(start + 3)};
    tgt_vld  = 2'b01;
    @(negedge clk);
    tgt_vld  = '0;
    T        = cyc;
    rdy_seen = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (scan_out !== 1'b0) begin n_err++; $display("FAIL scan_out_tied: got %b at cycle %0d expected 0", scan_out, i); end
      if (tgt_rdy[0] && rdy_seen < 0) rdy_seen = cyc;
      scan_en = (i >= 2 && i < 12);
      scan_in = i[0];
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
    n_cmp++; if (rdy_seen != T + 4*STEP_DIV) begin n_err++; $display("FAIL noscan_time: got cycle %0d expected cycle %0d", rdy_seen - T, 4*STEP_DIV); end
    n_cmp++; if (gray[CODE_W-1:0] !== g2(CODE_W'(start + 3))) begin n_err++; $display("FAIL noscan_code0: got %h expected %h", gray[CODE_W-1:0], g2(CODE_W'(start + 3))); end
    n_cmp++; if (gray[2*CODE_W-1:CODE_W] !== g2(CODE_W'(model[1]))) begin n_err++; $display("FAIL noscan_code1: got %h expected %h", gray[2*CODE_W-1:CODE_W], g2(CODE_W'(model[1]))); end
    model[0] = start + 3;
`endif
  endtask

  task automatic test_async_reset;
    int T;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    model[0] = 0;
    model[1] = 0;
    @(negedge clk);
    tgt_code = {CODE_W'(0), CODE_W'(2047)};
    tgt_vld  = 2'b01;
    @(negedge clk);
    tgt_vld = '0;
    T       = cyc;
    while (cyc < T + 1000*STEP_DIV + 1) @(negedge clk);
    n_cmp++; if (gray[CODE_W-1:0] !== g2(11'd1000)) begin n_err++; $display("FAIL ramp_1000: got %h expected %h", gray[CODE_W-1:0], g2(11'd1000)); end
    n_cmp++; if (tgt_rdy[0] !== 1'b0) begin n_err++; $display("FAIL ramp_busy: got %b expected 0", tgt_rdy[0]); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (gray !== '0)       begin n_err++; $display("FAIL async_gray: got %h expected 0", gray); end
    n_cmp++; if (tgt_rdy !== 2'b11) begin n_err++; $display("FAIL async_rdy: got %b expected 11", tgt_rdy); end
    n_cmp++; if (settled !== 2'b11) begin n_err++; $display("FAIL async_settled: got %b expected 11", settled); end
    n_cmp++; if (sel_clk !== 2'b00) begin n_err++; $display("FAIL async_sel: got %b expected 00", sel_clk); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_slew(2'b01, 5, 0, 0);
    test_slew(2'b11, 2, 3, 0);
    test_slew(2'b01, 6, 0, 7);
    test_sel_clk();
    test_scan();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within 1 ms");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/aibcr3_dcc_dlyctl_gen2.md
# aibcr3_dcc_dlyctl_gen2

Parametrised, multi-channel delay-code controller for the DCC/DLL delay lines. It accepts a binary target code per channel and slews the live code one LSB at a time at a programmable rate, so the delay line never sees a multi-bit jump. It drives each line's gray-coded control bus and the clock-source select (calibration path vs. `clk_dcd`). It sits between the DLL/DCC calibration logic and the delay-line instances, and adds a scan-loadable code chain on the functional clock.

## Interface
Parameters:
- `NCH`, 2: number of independent delay-line channels (≥1).
- `CODE_W`, 11: code width per channel (≥2).
- `STEP_DIV`, 4: clock cycles per code step, and the settle-hold length (≥1).

Ports:
- `clk` input 1: functional clock; all state is rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `dll_lock` input 1: 1 selects `clk_dcd` as delay-line source; 0 selects the launch/measure path.
- `tgt_vld` input NCH: per-channel target-valid.
- `tgt_code` input NCH*CODE_W: binary targets, channel c at `[c*CODE_W +: CODE_W]`.
- `tgt_rdy` output NCH: channel idle and able to accept a target.
- `settled` output NCH: channel idle and its code equals the last accepted target.
- `gray` output NCH*CODE_W: registered gray code of the live code, per channel.
- `sel_clk` output NCH: registered per-channel source select for the delay-line input mux.
- `scan_en` input 1: scan shift enable.
- `scan_in` input 1: scan serial input.
- `scan_out` output 1: scan serial output.

## Operation
- Per-channel state: `cur` (CODE_W binary), `tgt` (CODE_W), `div` counter (0..STEP_DIV-1), FSM {IDLE, SLEW, HOLD}.
- IDLE: `tgt_rdy`=1 and `settled`=1. On `tgt_vld`&`tgt_rdy`, latch `tgt` and clear `div`. Go to SLEW if `tgt_code`≠`cur`, else go to HOLD.
- SLEW: `div` increments each cycle. When `div`==STEP_DIV-1, `cur` moves ±1 toward `tgt` and `div` clears. When the stepped value equals `tgt`, go to HOLD on the same edge.
- HOLD: count STEP_DIV cycles, then go to IDLE.
- `tgt_vld` in SLEW or HOLD is ignored. No queueing; the source must hold `tgt_vld` until it sees `tgt_rdy`.
- Full unsigned range, no clamping or wrap. Code 0 to 2047 takes 2047 steps.
- `gray[c]` <= `cur[c]` ^ (`cur[c]`>>1), registered. Adjacent codes therefore differ in exactly one gray bit.
- `sel_clk[c]` samples `dll_lock` only when channel c is IDLE, so the source never switches mid-slew.
- Channels are fully independent apart from the shared scan chain.
- Scan (when compiled in): while `scan_en`=1, every FSM, `div` and `tgt` holds its value.
  - Chain V = {`cur[NCH-1]`,…,`cur[0]`} shifts each cycle: V <= {`scan_in`, V[N-1:1]}.
  - `scan_out` = V[0].
  - After `scan_en` falls, SLEW channels resume stepping from the loaded `cur` toward `tgt`.
  - IDLE channels whose loaded `cur`≠`tgt` report `settled`=0 but stay IDLE.

## Timing
- Reset values: `cur`=0, `tgt`=0, `div`=0, state IDLE, `gray`=0, `sel_clk`=0, `tgt_rdy`=all 1, `settled`=all 1, `scan_out`=0.
- Accept at edge T with distance d≥1:
  - SLEW from T+1.
  - `cur` changes at edges T+k·STEP_DIV, for k=1..d.
  - `gray` follows one edge later.
  - HOLD from T+d·STEP_DIV.
  - IDLE, with `tgt_rdy` and `settled` high, from T+(d+1)·STEP_DIV.
- d=0: HOLD at T+1, IDLE at T+1+STEP_DIV.
- `tgt_rdy` and `settled` are decoded from registered state, with no combinational path from inputs.
- `sel_clk` has one-cycle latency from `dll_lock` when IDLE.
- Reset asserted mid-slew clears everything immediately (asynchronous). `gray` shows 0 without waiting for a clock.
- `scan_en` asserted on the same edge as a scheduled step: the scan shift wins and the step is deferred, with `div` frozen.

## Configuration
- `AIBCR3_DCC_DLYCTL_SCAN_EN` defined: scan chain as described above.
- Not defined:
  - `scan_en` and `scan_in` are ignored.
  - `scan_out` is tied 0.
  - Ports remain present so instantiations are unchanged.

## Test plan
- Reset then target 5 on ch0 (STEP_DIV=4) -> `cur` steps at T+4,8,…,20; `gray` 001,011,010,110,111 each one cycle later; `tgt_rdy` high again at T+24.
- Ch0 from 5 to target 2 while ch1 goes to 3 in the same cycle -> ch0 decrements (gray 111,110,010,011) independently of ch1; each channel sees one gray-bit change per step.
- `tgt_vld` pulsed during SLEW with value 100 -> ignored; final code equals the original target.
- `dll_lock` 0→1 mid-slew on ch0, idle ch1 -> ch1 `sel_clk` rises next cycle; ch0 `sel_clk` rises only after ch0 returns to IDLE.
- Scan enabled: shift NCH*CODE_W bits loading ch0=0x3FF, ch1=0x001 during a slew -> FSMs frozen; `scan_out` emits the prior codes LSB-first; stepping resumes from 0x3FF after `scan_en` falls. With the macro undefined, `scan_out` stays 0 and codes are unchanged.
- Reset asserted at step 1000 of a 0→2047 ramp -> `gray`=0 and `tgt_rdy`=1 immediately, without a clock edge.
